// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC owner and prefetch FIFO feeding decode over valid/ready.
//            Optional perf counters are enabled with IFU_PERF_COUNTERS_EN.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef IFU_PERF_COUNTERS_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];

  logic w_pop;
  logic w_fetch;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  // A full FIFO may still fetch when its head leaves in the same cycle.
  assign w_fetch   = !redirect_valid & ((r_count < C_DEPTH) | w_pop);

  assign imem_addr = r_pc;
  assign out_instr = r_fifo_instr[r_rptr];
  assign out_pc    = r_fifo_pc[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_fetch) begin
        r_fifo_instr[r_wptr] <= imem_instr;
        r_fifo_pc[r_wptr]    <= r_pc;
        r_pc                 <= r_pc + 32'd4;
        r_wptr               <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_fetch) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (out_valid & !out_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit against a queue model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

  localparam int D = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: queue of {pc, instr} entries plus the model PC.
  logic [63:0] q[$];
  logic [31:0] mpc;
  logic [31:0] mfetch;
  logic [31:0] mstall;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef IFU_PERF_COUNTERS_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      32'hC:   return 32'h0030_8193;
      default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  assign imem_instr = memf(imem_addr);

  task automatic model_reset();
    q.delete();
    mpc    = 32'h0;
    mfetch = 32'h0;
    mstall = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, clock it, and advance the model; sample #1 after.
  task automatic tick(input logic redir, input logic [31:0] rpc, input logic rdy);
    logic pop, fetch;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    pop   = (q.size() != 0) && rdy;
    fetch = !redir && ((q.size() < D) || pop);
    if (fetch) mfetch = mfetch + 32'd1;
    if ((q.size() != 0) && !rdy) mstall = mstall + 32'd1;
    @(posedge clk);
    if (redir) begin
      q.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(q.pop_front());
      if (fetch) begin
        q.push_back({mpc, memf(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    do_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      bad++;
      $display("FAIL reset: valid=%b addr=%h pc=%h instr=%h required 0/0/0/0",
               out_valid, imem_addr, out_pc, out_instr);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] words [4];
    words[0] = 32'h0000_0013; words[1] = 32'h0010_0093;
    words[2] = 32'h0020_0113; words[3] = 32'h0030_8193;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 32'h0, 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== words[k]) begin
        bad++;
        $display("FAIL free_run[%0d]: valid=%b pc=%h instr=%h required 1 %h %h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), words[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (k >= 2) begin
        total++;
        if (imem_addr !== 32'h8 || out_pc !== 32'h0 || out_instr !== 32'h0000_0013 || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL backpressure[%0d]: addr=%h pc=%h instr=%h valid=%b required 8 0 00000013 1",
                   k, imem_addr, out_pc, out_instr, out_valid);
        end
      end
    end
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 32'h0, 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
        bad++;
        $display("FAIL bp_resume[%0d]: valid=%b pc=%h required 1 %h", k, out_valid, out_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b1, 32'h0000_0042, 1'b0);
    total++;
    if (imem_addr !== 32'h40 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL redirect_next: addr=%h valid=%b required 00000040 0", imem_addr, out_valid);
    end
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== memf(32'h40)) begin
      bad++;
      $display("FAIL redirect_first: valid=%b pc=%h instr=%h required 1 00000040 %h",
               out_valid, out_pc, out_instr, memf(32'h40));
    end
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h44) begin
      bad++;
      $display("FAIL redirect_second: valid=%b pc=%h required 1 00000044", out_valid, out_pc);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b1, 32'h0000_0103, 1'b1);
    total++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL redir_pop_next: valid=%b addr=%h required 0 00000100", out_valid, imem_addr);
    end
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      bad++;
      $display("FAIL redir_pop_first: valid=%b pc=%h required 1 00000100", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 32'hFFFF_FFFC, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_first: valid=%b pc=%h addr=%h required 1 fffffffc 00000000",
               out_valid, out_pc, imem_addr);
    end
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_0013) begin
      bad++;
      $display("FAIL wrap_second: valid=%b pc=%h instr=%h required 1 00000000 00000013",
               out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_random();
    logic        r;
    logic [31:0] t;
    logic        rdy;
    logic [63:0] h;
    for (int k = 0; k < 400; k++) begin
      r   = ($urandom_range(0, 9) == 0);
      t   = $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      tick(r, t, rdy);
      h = (q.size() != 0) ? q[0] : 64'h0;
      total++;
      if (imem_addr !== mpc || out_valid !== (q.size() != 0) ||
          (q.size() != 0 && (out_pc !== h[63:32] || out_instr !== h[31:0]))) begin
        bad++;
        $display("FAIL random[%0d]: addr=%h valid=%b pc=%h instr=%h required %h %b %h %h",
                 k, imem_addr, out_valid, out_pc, out_instr, mpc, (q.size() != 0), h[63:32], h[31:0]);
      end
`ifdef IFU_PERF_COUNTERS_EN
      total++;
      if (perf_fetch_cnt !== mfetch || perf_stall_cnt !== mstall) begin
        bad++;
        $display("FAIL perf[%0d]: fetch=%0d stall=%0d required %0d %0d",
                 k, perf_fetch_cnt, perf_stall_cnt, mfetch, mstall);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: valid=%b addr=%h required 0 00000000", out_valid, imem_addr);
    end
`ifdef IFU_PERF_COUNTERS_EN
    total++;
    if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin
      bad++;
      $display("FAIL async_reset_perf: fetch=%0d stall=%0d required 0 0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_0013) begin
      bad++;
      $display("FAIL async_reset_restart: valid=%b pc=%h instr=%h required 1 00000000 00000013",
               out_valid, out_pc, out_instr);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    model_reset();
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the combinational, word-aligned instruction memory.
- Owns the PC and drives the memory address each cycle.
- Captures the returned instruction word, with its PC, into a small prefetch FIFO.
- Presents entries to decode over a valid/ready handshake.
- Accepts branch/jump redirects that flush buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded at reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2: prefetch entries; power of two, minimum 2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- imem_addr, output, 32: fetch address; always equals the PC register.
- imem_instr, input, 32: instruction word; combinational response to imem_addr, same cycle.
- redirect_valid, input, 1: flush the FIFO and load a new PC.
- redirect_pc, input, 32: target PC; bits [1:0] forced to 0 internally.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: decode accepts the head entry.
- out_instr, output, 32: instruction word at FIFO head.
- out_pc, output, 32: PC of the FIFO head entry.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC, FIFO count = 0, read/write pointers = 0.
  - out_valid = 0; out_instr and out_pc = 0.
- Internal signals:
  - pop = out_valid & out_ready.
  - fetch = !redirect_valid & (count < FIFO_DEPTH | pop).
- Fetch cycle:
  - FIFO[wptr] <= {pc, imem_instr}.
  - pc <= pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - wptr advances modulo FIFO_DEPTH.
- No fetch: pc holds; imem_addr keeps driving pc.
- Pop: rptr advances; next entry (if any) appears on out_* the following cycle.
- Count update:
  - +1 on fetch only; -1 on pop only.
  - Unchanged when fetch and pop coincide; this includes the full-and-pop case, so a full FIFO refills in the same cycle.
- Latency: the instruction at PC p is fetched in cycle N and appears on out_* in cycle N+1. Steady-state throughput is 1 instruction/cycle with out_ready held high.
- Redirect (highest priority):
  - Cycle with redirect_valid = 1: count <= 0, rptr = wptr <= 0, pc <= {redirect_pc[31:2], 2'b00}.
  - A simultaneous pop is discarded; no fetch is written.
  - out_valid = 0 in the next cycle. The first post-redirect instruction appears on out_* 2 cycles after redirect_valid was sampled.
- Back-to-back redirects: the last one wins; out_valid stays 0 throughout.
- Output stability: while out_valid = 1 and out_ready = 0, out_instr and out_pc hold constant. They may change only on pop or redirect.
- Empty FIFO: out_valid = 0 and out_ready is ignored. out_instr and out_pc are don't-care, but must not be X after reset.
- Reset mid-stream: all state returns to reset values immediately, and buffered entries are lost. The first fetch after release is at RESET_PC.

Optional Feature:
- Macro: IFU_PERF_COUNTERS_EN.
- When defined, add outputs perf_fetch_cnt [31:0] and perf_stall_cnt [31:0]:
  - perf_fetch_cnt increments on every fetch.
  - perf_stall_cnt increments on every cycle with out_valid & !out_ready.
  - Both reset to 0, wrap at 2^32, and are not cleared by redirect.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Free-run after reset. Bench memory holds word 0 = 32'h00000013, word 1 = 32'h00100093, word 2 = 32'h00200113, word 3 = 32'h00308193; out_ready = 1. Required: from cycle 1 after reset release, out_pc = 0, 4, 8, 12 on consecutive cycles, with out_instr matching each word.
- Backpressure: out_ready = 0 for 5 cycles. Required: count saturates at 2; imem_addr holds at 8; out_pc stays 0 with out_instr = 32'h00000013. When out_ready returns to 1, the sequence continues 0, 4, 8 with no gap or duplicate.
- Redirect: redirect_valid pulsed with redirect_pc = 32'h0000_0042 while the FIFO is full. Required: next cycle imem_addr = 32'h40 and out_valid = 0; the following cycle out_pc = 32'h40. No stale entries appear.
- Redirect plus pop in the same cycle: the popped entry is consumed and not re-presented. The next presented out_pc equals the redirect target.
- Wrap: redirect to 32'hFFFF_FFFC with out_ready = 1. Required: out_pc = 32'hFFFF_FFFC, then 0.
- Async reset asserted mid-stream, between clock edges. Required: out_valid drops to 0 immediately and imem_addr = RESET_PC. With IFU_PERF_COUNTERS_EN defined, both counters read 0.
